// File: rtl/uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder
//   Knight-side end of the RemoteComm serial link. A UART receiver
//   deserializes bytes from RX and an assembler packs two consecutive good
//   bytes into a 16-bit command for cmd_proc. A UART transmitter serializes
//   an 8-bit response byte back out on TX. RX and TX run independently.
//
//   Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
//
// Parameters
//   BAUD_DIV      clk cycles per bit (>= 8)
//   TIMEOUT_BITS  inter-byte timeout in bit times (CMD_TIMEOUT_EN only)
//
// Optional feature macro
//   CMD_TIMEOUT_EN  when defined, a half-assembled command (first byte held)
//                   is discarded after TIMEOUT_BITS*BAUD_DIV idle clks.
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   RX           in   serial input, idle high, asynchronous to clk
//   TX           out  serial output, idle high
//   cmd          out  [15:0] assembled command {first byte, second byte}
//   cmd_rdy      out  cmd valid, held until clr_cmd_rdy
//   clr_cmd_rdy  in   acknowledge, clears cmd_rdy
//   resp         in   [7:0] response byte, sampled when trmt is accepted
//   trmt         in   1-clk pulse requesting transmission of resp
//   tx_done      out  response fully sent, held until next accepted trmt
// ---------------------------------------------------------------------------
module uart_cmd_responder #(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int CNT_W = $clog2(BAUD_DIV);

    typedef enum logic {RX_IDLE, RX_BUSY}  rx_state_t;
    typedef enum logic {WAIT_HI, WAIT_LO}  asm_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT}  tx_state_t;

    // ---------------- RX synchronizer ----------------
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ---------------- RX bit sampler ----------------
    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_baud_cnt;
    logic [3:0]       rx_bit_idx;
    logic [7:0]       rx_shift;
    logic             rx_start, rx_sample, rx_stop_smp, rx_false_start;
    logic             rx_good, rx_ferr;

    assign rx_start       = (rx_state == RX_IDLE) && rx_prev && !rx_sync;
    assign rx_sample      = (rx_state == RX_BUSY) && (rx_baud_cnt == '0);
    assign rx_false_start = rx_sample && (rx_bit_idx == 4'd0) && rx_sync;
    assign rx_stop_smp    = rx_sample && (rx_bit_idx == 4'd9);
    assign rx_good        = rx_stop_smp && rx_sync;
    assign rx_ferr        = rx_stop_smp && !rx_sync;

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE: if (rx_start) rx_state_nxt = RX_BUSY;
            RX_BUSY: if (rx_false_start || rx_stop_smp) rx_state_nxt = RX_IDLE;
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // First sample lands mid start bit, later ones one bit time apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_baud_cnt <= '0;
            rx_bit_idx  <= 4'd0;
        end else if (rx_start) begin
            rx_baud_cnt <= CNT_W'(BAUD_DIV / 2 - 1);
            rx_bit_idx  <= 4'd0;
        end else if (rx_state == RX_BUSY) begin
            if (rx_baud_cnt == '0) begin
                rx_baud_cnt <= CNT_W'(BAUD_DIV - 1);
                rx_bit_idx  <= rx_bit_idx + 4'd1;
            end else begin
                rx_baud_cnt <= rx_baud_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_sample && (rx_bit_idx >= 4'd1) && (rx_bit_idx <= 4'd8))
            rx_shift <= {rx_sync, rx_shift[7:1]};
    end

    // ---------------- stage p1: received byte handed to assembler ----------------
    logic       byte_vld_p1, ferr_p1;
    logic [7:0] byte_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_vld_p1 <= 1'b0;
            ferr_p1     <= 1'b0;
        end else begin
            byte_vld_p1 <= rx_good;
            ferr_p1     <= rx_ferr;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_good) byte_p1 <= rx_shift;
    end

    // ---------------- command assembler ----------------
    asm_state_t asm_state, asm_state_nxt;
    logic [7:0] hi_byte;
    logic       timeout;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    logic [TO_W-1:0] to_cnt;

    // Only idle line time counts; a frame in flight holds the counter at
    // zero so a slow second byte is never cut off mid-reception.
    always_ff @(posedge clk) begin
        if (rst)
            to_cnt <= '0;
        else if ((asm_state != WAIT_LO) || rx_start || (rx_state == RX_BUSY))
            to_cnt <= '0;
        else if (!timeout)
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = (to_cnt == TO_W'(TO_LIMIT));
`else
    // Feature disabled: WAIT_LO waits forever; this expression is constant 0.
    assign timeout = (TIMEOUT_BITS < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) asm_state <= WAIT_HI;
        else     asm_state <= asm_state_nxt;
    end

    always_comb begin
        asm_state_nxt = asm_state;
        case (asm_state)
            WAIT_HI: if (byte_vld_p1) asm_state_nxt = WAIT_LO;
            WAIT_LO: if (byte_vld_p1 || ferr_p1 || timeout) asm_state_nxt = WAIT_HI;
            default: asm_state_nxt = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if ((asm_state == WAIT_HI) && byte_vld_p1) hi_byte <= byte_p1;
    end

    // Set has priority over the consumer acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd     <= 16'h0000;
            cmd_rdy <= 1'b0;
        end else if ((asm_state == WAIT_LO) && byte_vld_p1) begin
            cmd     <= {hi_byte, byte_p1};
            cmd_rdy <= 1'b1;
        end else if ((asm_state == WAIT_HI) && byte_vld_p1) begin
            cmd_rdy <= 1'b0;
        end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_baud_cnt;
    logic [3:0]       tx_bit_cnt;
    logic [8:0]       tx_shift;
    logic             tx_accept, tx_bit_end, tx_last;

    assign tx_accept  = (tx_state == TX_IDLE) && trmt;
    assign tx_bit_end = (tx_state == TX_XMIT) && (tx_baud_cnt == CNT_W'(BAUD_DIV - 1));
    assign tx_last    = tx_bit_end && (tx_bit_cnt == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE: if (trmt)    tx_state_nxt = TX_XMIT;
            TX_XMIT: if (tx_last) tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX is registered: the start bit is driven directly on accept, the
    // shift register then supplies data bits and the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            TX          <= 1'b1;
            tx_done     <= 1'b0;
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= 4'd0;
        end else if (tx_accept) begin
            TX          <= 1'b0;
            tx_done     <= 1'b0;
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= 4'd0;
        end else if (tx_last) begin
            TX          <= 1'b1;
            tx_done     <= 1'b1;
            tx_baud_cnt <= '0;
        end else if (tx_bit_end) begin
            TX          <= tx_shift[0];
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= tx_bit_cnt + 4'd1;
        end else if (tx_state == TX_XMIT) begin
            tx_baud_cnt <= tx_baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_accept)
            tx_shift <= {1'b1, resp};
        else if (tx_bit_end)
            tx_shift <= {1'b1, tx_shift[8:1]};
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

    localparam int BAUD_DIV     = 16;
    localparam int TIMEOUT_BITS = 4;
    localparam int TO_CLKS      = TIMEOUT_BITS * BAUD_DIV;

`ifdef CMD_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    uart_cmd_responder #(
        .BAUD_DIV    (BAUD_DIV),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .trmt       (trmt),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending first byte, last command, ready flag.
    logic [7:0]  m_hi;
    bit          m_hi_vld;
    logic [15:0] m_cmd;
    bit          m_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      RX = 1'b0;
            else if (i == 9) RX = stop;
            else             RX = b[i-1];
            wait_clks(BAUD_DIV);
        end
        RX = 1'b1;
        wait_clks(2);
    endtask

    task automatic model_byte(input logic [7:0] b, input logic stop, input int gap);
        if (TIMEOUT_ON && (gap > TO_CLKS)) m_hi_vld = 1'b0;
        if (!stop) begin
            m_hi_vld = 1'b0;
        end else if (m_hi_vld) begin
            m_cmd    = {m_hi, b};
            m_rdy    = 1'b1;
            m_hi_vld = 1'b0;
        end else begin
            m_hi     = b;
            m_hi_vld = 1'b1;
            m_rdy    = 1'b0;
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop, input int gap, input string tag);
        wait_clks(gap);
        send_frame(b, stop);
        model_byte(b, stop, gap);
        check({tag, "_cmd"}, 32'(cmd), 32'(m_cmd));
        check({tag, "_rdy"}, 32'(cmd_rdy), 32'(m_rdy));
    endtask

    task automatic pulse_clr(input string tag);
        clr_cmd_rdy = 1'b1;
        wait_clks(1);
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        check({tag, "_clr_rdy"}, 32'(cmd_rdy), 32'(m_rdy));
        check({tag, "_clr_cmd"}, 32'(cmd), 32'(m_cmd));
    endtask

    // Sends r and checks every bit mid-way plus tx_done timing. With retrig a
    // second trmt is pulsed 50 clks in, which must be ignored.
    task automatic tx_check(input logic [7:0] r, input bit retrig, input string tag);
        logic [9:0] frame;
        frame = {1'b1, r, 1'b0};
        resp = r;
        trmt = 1'b1;
        wait_clks(1);
        trmt = 1'b0;
        for (int n = 1; n <= 160; n++) begin
            if (retrig && n == 50) begin
                resp = ~r;
                trmt = 1'b1;
            end else if (n == 51) begin
                trmt = 1'b0;
            end
            wait_clks(1);
            if (n == 1) check({tag, "_start_edge"}, 32'(TX), 32'd0);
            if ((n % BAUD_DIV) == BAUD_DIV / 2)
                check($sformatf("%s_bit%0d", tag, n / BAUD_DIV), 32'(TX), 32'(frame[n / BAUD_DIV]));
            if (n == 159) check({tag, "_done_early"}, 32'(tx_done), 32'd0);
            if (n == 160) begin
                check({tag, "_done"}, 32'(tx_done), 32'd1);
                check({tag, "_idle_tx"}, 32'(TX), 32'd1);
            end
        end
        wait_clks(20);
        check({tag, "_done_hold"}, 32'(tx_done), 32'd1);
        check({tag, "_idle_hold"}, 32'(TX), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit         stop;
        int         gap;

        rst = 1'b1; RX = 1'b1; trmt = 1'b0; clr_cmd_rdy = 1'b0; resp = 8'h00;
        m_hi = 8'h00; m_hi_vld = 1'b0; m_cmd = 16'h0000; m_rdy = 1'b0;
        wait_clks(3);
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        wait_clks(5);

        // Basic command and acknowledge
        rx_byte(8'h20, 1'b1, 0, "c2001_a");
        rx_byte(8'h01, 1'b1, 0, "c2001_b");
        check("c2001_exact", 32'(cmd), 32'h2001);
        pulse_clr("c2001");
        pulse_clr("c2001_again");

        // Response transmit with an ignored retrigger
        tx_check(8'hA5, 1'b1, "txa5");

        // Framing error dropped
        rx_byte(8'h40, 1'b0, 4, "ferr");
        rx_byte(8'h12, 1'b1, 4, "c1234_a");
        rx_byte(8'h34, 1'b1, 0, "c1234_b");
        check("c1234_exact", 32'(cmd), 32'h1234);

        // Short glitch in the middle of a command changes nothing
        rx_byte(8'h11, 1'b1, 4, "glitch_a");
        RX = 1'b0;
        wait_clks(3);
        RX = 1'b1;
        wait_clks(20);
        check("glitch_cmd", 32'(cmd), 32'(m_cmd));
        check("glitch_rdy", 32'(cmd_rdy), 32'(m_rdy));
        rx_byte(8'h22, 1'b1, 0, "glitch_b");
        check("glitch_exact", 32'(cmd), 32'h1122);

        // Inter-byte gap longer than the timeout
        rx_byte(8'h55, 1'b1, 4, "to_a");
        rx_byte(8'h66, 1'b1, 5 * BAUD_DIV, "to_b");
        rx_byte(8'h77, 1'b1, 0, "to_c");
        check("to_exact", 32'(cmd), TIMEOUT_ON ? 32'h6677 : 32'h5566);
        if (m_hi_vld) rx_byte(8'h88, 1'b1, 0, "to_flush");

        // RX and TX concurrently
        fork
            begin
                rx_byte(8'hC3, 1'b1, 3, "conc_a");
                rx_byte(8'h3C, 1'b1, 0, "conc_b");
            end
            tx_check(8'h5E, 1'b0, "conc_tx");
        join

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            gap  = ($urandom_range(0, 4) == 0) ? $urandom_range(90, 130) : $urandom_range(0, 8);
            rx_byte(b, stop, gap, $sformatf("rnd%0d", k));
            if (m_rdy && $urandom_range(0, 1) == 1) pulse_clr($sformatf("rnd%0d", k));
            if ((k % 10) == 9) tx_check(8'($urandom), 1'($urandom), $sformatf("rndtx%0d", k));
        end

        // Mid-operation reset with a held first byte, a partial frame and a transmission
        if (!m_hi_vld) rx_byte(8'h5A, 1'b1, 2, "mr_pre");
        if (m_cmd == 16'h0000) begin
            rx_byte(8'hE1, 1'b1, 0, "mr_pre2");
            rx_byte(8'h5A, 1'b1, 0, "mr_pre3");
        end
        resp = 8'h0F;
        trmt = 1'b1;
        RX   = 1'b0;
        wait_clks(1);
        trmt = 1'b0;
        wait_clks(40);
        rst = 1'b1;
        RX  = 1'b1;
        wait_clks(1);
        check("mr_tx", 32'(TX), 32'd1);
        check("mr_cmd", 32'(cmd), 32'd0);
        check("mr_rdy", 32'(cmd_rdy), 32'd0);
        check("mr_done", 32'(tx_done), 32'd0);
        wait_clks(2);
        rst = 1'b0;
        m_hi_vld = 1'b0; m_cmd = 16'h0000; m_rdy = 1'b0;
        wait_clks(30);
        check("mr_tx_quiet", 32'(TX), 32'd1);
        check("mr_done_quiet", 32'(tx_done), 32'd0);
        rx_byte(8'h9A, 1'b1, 0, "mr_post_a");
        rx_byte(8'hBC, 1'b1, 0, "mr_post_b");
        check("mr_post_exact", 32'(cmd), 32'h9ABC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
